// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - SPI mode-0 slave turning MCU frames into register-bus accesses
module spi_reg_bridge #(
    parameter int ADDR_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_clk,
    input  logic              spi_ncs,
    input  logic              spi_din,
    output logic              spi_dout,
    output logic              r_valid,
    output logic              r_wen,
    output logic [ADDR_W-1:0] r_addr,
    output logic [31:0]       r_wdata,
    input  logic [31:0]       r_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDUMMY, S_RDATA
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, ncs_sync_q, din_sync_q;
    logic                   sck_prev_q, ncs_prev_q;

    // Sync flops clear to 0 so a chip select already low at reset release
    // never looks like a falling edge; the bridge waits for a fresh frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q <= '0;
            ncs_sync_q <= '0;
            din_sync_q <= '0;
            sck_prev_q <= 1'b0;
            ncs_prev_q <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk};
            ncs_sync_q <= {ncs_sync_q[SYNC_STAGES-2:0], spi_ncs};
            din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], spi_din};
            sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
            ncs_prev_q <= ncs_sync_q[SYNC_STAGES-1];
        end
    end

    logic sck_s, ncs_s, din_s, sck_rise, sck_fall, ncs_fall;
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign ncs_s    = ncs_sync_q[SYNC_STAGES-1];
    assign din_s    = din_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign ncs_fall = ~ncs_s & ncs_prev_q;

    state_t            state_q;
    logic [2:0]        bit_cnt_q;
    logic [1:0]        byte_cnt_q;
    logic [31:0]       rx_q, tx_q, word_d;
    logic              rd_pend_q, dout_q, valid_q, wen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              byte_done, word_done;

    // The command and address bytes land in word_d[15:0] at the end of ADDR.
    assign word_d    = {rx_q[30:0], din_s};
    assign byte_done = (bit_cnt_q == 3'd7);
    assign word_done = byte_done && (byte_cnt_q == 2'd3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            rd_pend_q  <= 1'b0;
            dout_q     <= 1'b0;
            valid_q    <= 1'b0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            valid_q <= 1'b0;
            wen_q   <= 1'b0;
            if (valid_q && wen_q)
                addr_q <= addr_q + ADDR_W'(1);
            if (valid_q && !wen_q)
                tx_q <= r_rdata;
            // A queued prefetch still fires even if the frame has just ended.
            if (rd_pend_q) begin
                valid_q   <= 1'b1;
                rd_pend_q <= 1'b0;
            end
            if (state_q != S_IDLE && ncs_s) begin
                state_q    <= S_IDLE;
                bit_cnt_q  <= '0;
                byte_cnt_q <= '0;
                rx_q       <= '0;
                dout_q     <= 1'b0;
            end else if (state_q == S_IDLE) begin
                if (ncs_fall) begin
                    state_q    <= S_CMD;
                    bit_cnt_q  <= '0;
                    byte_cnt_q <= '0;
                    rx_q       <= '0;
                end
            end else begin
                if (sck_rise) begin
                    rx_q      <= word_d;
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (byte_done)
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                    case (state_q)
                        S_CMD:    if (byte_done) state_q <= S_ADDR;
                        S_ADDR: if (byte_done) begin
                            addr_q     <= word_d[ADDR_W-1:0];
                            byte_cnt_q <= '0;
                            if (word_d[15]) begin
                                state_q <= S_WDATA;
                            end else begin
                                state_q <= S_RDUMMY;
                                valid_q <= 1'b1;
                            end
                        end
                        S_RDUMMY: if (byte_done) begin
                            state_q    <= S_RDATA;
                            byte_cnt_q <= '0;
                        end
                        S_WDATA: if (word_done) begin
                            wdata_q <= word_d;
                            valid_q <= 1'b1;
                            wen_q   <= 1'b1;
                        end
                        S_RDATA: if (word_done) begin
                            addr_q    <= addr_q + ADDR_W'(1);
                            rd_pend_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                if (sck_fall && state_q == S_RDATA) begin
                    dout_q <= tx_q[31];
                    tx_q   <= {tx_q[30:0], 1'b0};
                end
            end
        end
    end

    assign spi_dout = dout_q;
    assign r_valid  = valid_q;
    assign r_wen    = wen_q;
    assign r_addr   = addr_q;
    assign r_wdata  = wdata_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb/tb_spi_reg_bridge.sv - self-checking bench for spi_reg_bridge
module tb_spi_reg_bridge;
    localparam int HALF = 6;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        spi_clk = 1'b0, spi_ncs = 1'b1, spi_din = 1'b0;
    logic        spi_dout, r_valid, r_wen;
    logic [11:0] r_addr;
    logic [31:0] r_wdata, r_rdata;

    logic [31:0] mem     [4096];
    logic [31:0] ref_mem [4096];

    always #5 clk = ~clk;
    assign r_rdata = mem[r_addr];

    spi_reg_bridge #(.ADDR_W(12), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .spi_clk(spi_clk), .spi_ncs(spi_ncs),
        .spi_din(spi_din), .spi_dout(spi_dout), .r_valid(r_valid), .r_wen(r_wen),
        .r_addr(r_addr), .r_wdata(r_wdata), .r_rdata(r_rdata)
    );

    int errors = 0, checks = 0;

    typedef struct {
        bit          wen;
        logic [11:0] addr;
        logic [31:0] data;
    } acc_t;
    acc_t obs_q[$];
    acc_t mon_a;
    bit   prev_valid = 1'b0;

    always @(negedge clk) begin
        if (r_valid) begin
            mon_a.wen  = r_wen;
            mon_a.addr = r_addr;
            mon_a.data = r_wdata;
            obs_q.push_back(mon_a);
            checks++;
            if (prev_valid) begin
                errors++;
                $display("FAIL back_to_back_valid: strobe at %h follows a strobe, required idle gap", r_addr);
            end
            if (r_wen) mem[r_addr] <= r_wdata;
        end
        prev_valid = r_valid;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    logic        miso_bits[$];
    bit          f_wr, f_gap;
    logic [11:0] f_addr;
    int          f_nw, f_cut;
    logic [31:0] f_data[3];
    logic [31:0] got_words[3];

    task automatic shift_bit(input bit b);
        spi_din = b;
        repeat (HALF) @(negedge clk);
        miso_bits.push_back(spi_dout);
        spi_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        spi_clk = 1'b0;
    endtask

    task automatic shift_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) shift_bit(v[i]);
    endtask

    task automatic run_frame();
        int total, j;
        bit b;
        miso_bits.delete();
        obs_q.delete();
        total = f_wr ? f_nw * 32 : 8 + f_nw * 32;
        if (f_cut >= 0) total = f_cut;
        spi_ncs = 1'b0;
        repeat (4) @(negedge clk);
        shift_byte({f_wr, 3'b000, f_addr[11:8]});
        shift_byte(f_addr[7:0]);
        for (int i = 0; i < total; i++) begin
            j = f_wr ? i : i - 8;
            b = (j < 0) ? 1'b0 : f_data[j / 32][31 - (j % 32)];
            if (f_gap && (i % 8 == 0)) repeat ($urandom_range(0, 3) * HALF) @(negedge clk);
            shift_bit(b);
        end
        repeat (HALF) @(negedge clk);
        spi_ncs = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    // Frame-level reference: a write of N whole words touches addr..addr+N-1,
    // a read of N words touches addr..addr+N (the last is the prefetch).
    task automatic model_and_check(input string tag);
        acc_t        exp_q[$];
        acc_t        e;
        int          cw, n;
        logic [31:0] w;
        logic        pre;
        if (f_wr) begin
            cw = (f_cut < 0) ? f_nw : f_cut / 32;
            for (int i = 0; i < cw; i++) begin
                e.wen  = 1'b1;
                e.addr = f_addr + 12'(i);
                e.data = f_data[i];
                exp_q.push_back(e);
                ref_mem[e.addr] = f_data[i];
            end
        end else begin
            for (int i = 0; i <= f_nw; i++) begin
                e.wen  = 1'b0;
                e.addr = f_addr + 12'(i);
                e.data = '0;
                exp_q.push_back(e);
            end
        end
        check({tag, "_strobe_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_strobe%0d", tag, i),
                  {19'd0, obs_q[i].wen, obs_q[i].addr, obs_q[i].wen ? obs_q[i].data : 32'd0},
                  {19'd0, exp_q[i].wen, exp_q[i].addr, exp_q[i].data});
        if (!f_wr) begin
            pre = 1'b0;
            for (int k = 0; k < 24; k++) pre |= miso_bits[k];
            check({tag, "_miso_idle_zero"}, 64'(pre), 64'd0);
            for (int wi = 0; wi < f_nw; wi++) begin
                w = '0;
                for (int k = 0; k < 32; k++) w = {w[30:0], miso_bits[24 + wi * 32 + k]};
                got_words[wi] = w;
                check($sformatf("%s_miso_word%0d", tag, wi), 64'(w), 64'(ref_mem[f_addr + 12'(wi)]));
            end
        end
    endtask

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        int          nw;
        int          cut;
        logic [31:0] d0, d1, d2;
        int          exp_n;
        logic [11:0] exp_first, exp_last;
        logic [31:0] exp_word0;
    } vec_t;
    vec_t tbl[6];

    initial begin
        logic [31:0] v, w0;
        tbl[0] = '{1'b1, 12'h012, 1, -1, 32'hDEADBEEF, 32'h0, 32'h0, 1, 12'h012, 12'h012, 32'hDEADBEEF};
        tbl[1] = '{1'b0, 12'h034, 1, -1, 32'h0, 32'h0, 32'h0, 2, 12'h034, 12'h035, 32'h0000009C};
        tbl[2] = '{1'b1, 12'hFFF, 3, -1, 32'h01020304, 32'hA5A5A5A5, 32'hFFFFFFFF, 3, 12'hFFF, 12'h001, 32'h01020304};
        tbl[3] = '{1'b0, 12'h100, 2, -1, 32'h0, 32'h0, 32'h0, 3, 12'h100, 12'h102, 32'h00000300};
        tbl[4] = '{1'b1, 12'h050, 1, 20, 32'h11223344, 32'h0, 32'h0, 0, 12'h0, 12'h0, 32'h0};
        tbl[5] = '{1'b1, 12'h050, 1, -1, 32'hCAFEF00D, 32'h0, 32'h0, 1, 12'h050, 12'h050, 32'hCAFEF00D};
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 32'(i * 3);
            ref_mem[i] = 32'(i * 3);
        end

        repeat (5) @(negedge clk);
        check("reset_outputs", {17'd0, r_valid, r_wen, r_addr, r_wdata, spi_dout}, 64'd0);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);

        f_gap = 1'b0;
        for (int i = 0; i < 6; i++) begin
            f_wr = tbl[i].wr; f_addr = tbl[i].addr; f_nw = tbl[i].nw; f_cut = tbl[i].cut;
            f_data[0] = tbl[i].d0; f_data[1] = tbl[i].d1; f_data[2] = tbl[i].d2;
            run_frame();
            model_and_check($sformatf("v%0d", i));
            check($sformatf("v%0d_count", i), 64'(obs_q.size()), 64'(tbl[i].exp_n));
            if (tbl[i].exp_n > 0 && obs_q.size() > 0) begin
                w0 = f_wr ? obs_q[0].data : got_words[0];
                check($sformatf("v%0d_first_addr", i), 64'(obs_q[0].addr), 64'(tbl[i].exp_first));
                check($sformatf("v%0d_last_addr", i), 64'(obs_q[obs_q.size() - 1].addr), 64'(tbl[i].exp_last));
                check($sformatf("v%0d_word0", i), 64'(w0), 64'(tbl[i].exp_word0));
            end
        end

        // Reset pulsed in the middle of a read data word.
        miso_bits.delete();
        spi_ncs = 1'b0;
        repeat (4) @(negedge clk);
        shift_byte(8'h02); shift_byte(8'h00); shift_byte(8'h00);
        for (int i = 0; i < 10; i++) shift_bit(1'b1);
        reset_n = 1'b0;
        #1;
        check("reset_mid_read", {17'd0, r_valid, r_wen, r_addr, r_wdata, spi_dout}, 64'd0);
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        obs_q.delete();
        shift_byte(8'h80); shift_byte(8'h00);
        for (int i = 0; i < 4; i++) shift_byte(8'h5A);
        repeat (16) @(negedge clk);
        check("no_resync_without_ncs_edge", 64'(obs_q.size()), 64'd0);
        spi_ncs = 1'b1;
        repeat (8) @(negedge clk);
        f_wr = 1'b0; f_addr = 12'h034; f_nw = 1; f_cut = -1;
        run_frame();
        model_and_check("post_reset");
        check("post_reset_word", 64'(got_words[0]), 64'h9C);

        for (int i = 0; i < 4096; i++) begin
            v = $urandom;
            mem[i]     = v;
            ref_mem[i] = v;
        end
        f_gap = 1'b1;
        for (int t = 0; t < 16; t++) begin
            f_wr   = 1'($urandom_range(0, 1));
            f_addr = ($urandom_range(0, 3) == 0) ? 12'hFFE + 12'($urandom_range(0, 1)) : 12'($urandom);
            f_nw   = $urandom_range(1, 3);
            for (int k = 0; k < 3; k++) f_data[k] = $urandom;
            f_cut  = (f_wr && $urandom_range(0, 3) == 0) ? $urandom_range(1, f_nw * 32 - 1) : -1;
            run_frame();
            model_and_check($sformatf("rnd%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
